// File: rtl/shake_padder.sv
// SHAKE message padder.
// Accepts a little-endian byte stream packed into 64-bit lanes and emits
// complete rate-sized blocks carrying the SHAKE domain bits (0x1F) and the
// final pad10*1 bit (0x80 in the last byte of the block). Data words pass
// straight through with zero latency. Padding-only words are generated
// internally while upstream input is held off.
module shake_padder #(
    parameter int WORD_W = 64,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rate_sel,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_last,
    input  logic [3:0]        in_bytes,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_block_last,
    output logic              out_msg_last,
    output logic [CNT_W-1:0]  rate_words
);

    localparam int NBYTES = WORD_W / 8;
    localparam logic [CNT_W-1:0] RATE_128 = CNT_W'(21);
    localparam logic [CNT_W-1:0] RATE_256 = CNT_W'(17);

    typedef enum logic {
        S_DATA = 1'b0,
        S_PAD  = 1'b1
    } state_t;

    state_t             state_reg;
    state_t             state_next;
    logic [CNT_W-1:0]   wcnt_reg;
    logic               pad_first_reg;
    logic               msg_active_reg;
    logic [CNT_W-1:0]   rate_words_reg;

    logic [CNT_W-1:0]   cur_rate;
    logic               block_end;
    logic [3:0]         n_eff;
    logic               partial;
    logic               xfer;
    logic [WORD_W-1:0]  data_word;
    logic [WORD_W-1:0]  pad_word;

    // The first word of a message has no latched rate yet, so it follows
    // the live rate_sel; every later word uses the rate latched at start.
    assign cur_rate  = msg_active_reg ? rate_words_reg
                                      : (rate_sel ? RATE_256 : RATE_128);
    assign block_end = (wcnt_reg == (cur_rate - CNT_W'(1)));

    // Byte counts above a full lane saturate to a full lane.
    assign n_eff   = (in_bytes > 4'd8) ? 4'd8 : in_bytes;
    assign partial = in_last && (n_eff < 4'd8);
    assign xfer    = out_valid && out_ready;

    assign rate_words = rate_words_reg;

    // Per-byte lane construction: a short final word keeps its valid bytes,
    // gets 0x1F right after them and zeros above; when that word also closes
    // the block, the top byte additionally carries the 0x80 end bit.
    // Pad-only words hold at most 0x1F in byte 0 and 0x80 in the top byte.
    generate
        for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane_byte
            logic [7:0] in_byte;
            logic [7:0] masked_byte;
            logic [7:0] end_bit;
            logic [7:0] dom_bit;

            assign in_byte     = in_data[8*gi +: 8];
            assign masked_byte = !partial              ? in_byte :
                                 (4'(gi) <  n_eff)     ? in_byte :
                                 (4'(gi) == n_eff)     ? 8'h1F   : 8'h00;
            assign end_bit     = ((gi == NBYTES-1) && block_end) ? 8'h80 : 8'h00;
            assign dom_bit     = ((gi == 0) && pad_first_reg)    ? 8'h1F : 8'h00;

            assign data_word[8*gi +: 8] = masked_byte | (partial ? end_bit : 8'h00);
            assign pad_word[8*gi +: 8]  = dom_bit | end_bit;
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_DATA;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state: leave pass-through when the final word does not finish the
    // padding on its own; return once the padded block's last lane goes out.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_DATA: begin
                if (xfer && in_last && !(partial && block_end)) begin
                    state_next = S_PAD;
                end
            end
            S_PAD: begin
                if (xfer && block_end) begin
                    state_next = S_DATA;
                end
            end
            default: state_next = S_DATA;
        endcase
    end

    // Outputs: combinational pass-through in S_DATA, generated pad words in
    // S_PAD; everything is forced idle while reset is held.
    always_comb begin
        in_ready       = 1'b0;
        out_valid      = 1'b0;
        out_data       = '0;
        out_block_last = 1'b0;
        out_msg_last   = 1'b0;
        if (rst) begin
            case (state_reg)
                S_DATA: begin
                    out_valid      = in_valid;
                    in_ready       = out_ready;
                    out_data       = data_word;
                    out_block_last = block_end;
                    out_msg_last   = partial && block_end;
                end
                S_PAD: begin
                    out_valid      = 1'b1;
                    out_data       = pad_word;
                    out_block_last = block_end;
                    out_msg_last   = block_end;
                end
                default: begin
                    out_valid = 1'b0;
                end
            endcase
        end
    end

    // Lane counter, pad marker and per-message rate latch, all advanced on
    // output word transfers (in S_DATA this is also the input handshake).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wcnt_reg       <= '0;
            pad_first_reg  <= 1'b0;
            msg_active_reg <= 1'b0;
            rate_words_reg <= RATE_128;
        end else if (xfer) begin
            wcnt_reg       <= block_end ? '0 : (wcnt_reg + CNT_W'(1));
            // Only a full final lane leaves the domain byte for the pad phase.
            pad_first_reg  <= (state_reg == S_DATA) && in_last && !partial;
            msg_active_reg <= !out_msg_last;
            if (!msg_active_reg) begin
                rate_words_reg <= rate_sel ? RATE_256 : RATE_128;
            end
        end
    end

endmodule

// File: tb/tb_shake_padder.sv
// Directed bench for shake_padder: byte-level padding reference, hand-computed
// lane constants, stalls, mid-message rate_sel changes and reset mid-pad.
module tb_shake_padder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rate_sel;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        in_last;
    logic [3:0]  in_bytes;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        out_block_last;
    logic        out_msg_last;
    logic [4:0]  rate_words;

    int tests = 0;
    int fails = 0;

    logic [7:0]  msg  [0:511];
    logic [7:0]  expb [0:511];
    logic [63:0] got_d  [0:127];
    logic        got_bl [0:127];
    logic        got_ml [0:127];
    int          got_n;

    always #5 clk = ~clk;

    shake_padder #(.WORD_W(64), .CNT_W(5)) dut (
        .clk            (clk),
        .rst            (rst_n),
        .rate_sel       (rate_sel),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .in_last        (in_last),
        .in_bytes       (in_bytes),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_block_last (out_block_last),
        .out_msg_last   (out_msg_last),
        .rate_words     (rate_words)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic fill_msg();
        for (int k = 0; k < 512; k++) msg[k] = 8'(k);
    endtask

    // Sends one message of len bytes and collects the output until out_msg_last,
    // then checks every word against a byte-level reference padding.
    task automatic run_msg(input int len, input bit rsel, input bit stall,
                           input bit toggle, input int exp_rate, input string tag);
        int nwords, lb, idx, cyc, rb, nblk, total, expw, pad_rdy, rw_bad;
        bit done;
        logic [63:0] w, e;
        nwords  = (len == 0) ? 1 : (len + 7) / 8;
        lb      = len - 8 * (nwords - 1);
        rb      = exp_rate * 8;
        nblk    = len / rb + 1;
        total   = nblk * rb;
        expw    = nblk * exp_rate;
        for (int k = 0; k < total; k++) expb[k] = (k < len) ? msg[k] : 8'h00;
        expb[len]       = expb[len] | 8'h1F;
        expb[total - 1] = expb[total - 1] | 8'h80;

        idx = 0; cyc = 0; got_n = 0; pad_rdy = 0; rw_bad = 0; done = 1'b0;
        while (!done && cyc < 1000) begin
            for (int b = 0; b < 8; b++) begin
                int k;
                k = 8 * idx + b;
                w[8*b +: 8] = (k < len && k < 512) ? msg[k] : 8'hEE;
            end
            in_valid  = (idx < nwords);
            in_data   = w;
            in_last   = (idx == nwords - 1);
            in_bytes  = (idx == nwords - 1) ? 4'(lb) : 4'd2;
            rate_sel  = (toggle && idx > 0) ? ~rate_sel : rsel;
            out_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            @(negedge clk);
            if (out_valid && out_ready && got_n < 128) begin
                got_d[got_n]  = out_data;
                got_bl[got_n] = out_block_last;
                got_ml[got_n] = out_msg_last;
                got_n++;
                if (out_msg_last) done = 1'b1;
            end
            if (idx == nwords && in_ready) pad_rdy++;
            if (idx > 0 && rate_words !== 5'(exp_rate)) rw_bad++;
            if (in_valid && in_ready) idx++;
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        check({tag, " done"}, 64'(done), 64'd1);
        check({tag, " accepted"}, 64'(idx), 64'(nwords));
        check({tag, " word count"}, 64'(got_n), 64'(expw));
        check({tag, " in_ready in pad"}, 64'(pad_rdy), 64'd0);
        check({tag, " rate_words stable"}, 64'(rw_bad), 64'd0);
        for (int j = 0; j < expw && j < got_n; j++) begin
            for (int b = 0; b < 8; b++) e[8*b +: 8] = expb[8*j + b];
            check($sformatf("%s w%0d data", tag, j), got_d[j], e);
            check($sformatf("%s w%0d flags", tag, j),
                  {62'd0, got_bl[j], got_ml[j]},
                  {62'd0, (j % exp_rate) == exp_rate - 1, j == expw - 1});
        end
        $display("[TB] %s: len=%0d words=%0d", tag, len, got_n);
    endtask

    initial begin
        // Reset state: outputs held idle even with live handshake inputs.
        rst_n = 1'b0; rate_sel = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        in_data = 64'h0; in_last = 1'b0; in_bytes = 4'd0;
        #12;
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0; rate_sel = 1'b0;
        #1;
        check("rst rate_words", 64'(rate_words), 64'd21);
        @(posedge clk);
        #1;

        // SHAKE128 three-byte message.
        fill_msg();
        msg[0] = 8'hAA; msg[1] = 8'hBB; msg[2] = 8'hCC;
        run_msg(3, 1'b0, 1'b0, 1'b0, 21, "s128_3B");
        check("s128_3B w0 const", got_d[0], 64'h000000001FCCBBAA);
        check("s128_3B w20 const", got_d[20], 64'h8000000000000000);

        // Back-to-back: SHAKE256 with a full final lane on a block boundary.
        fill_msg();
        run_msg(136, 1'b1, 1'b0, 1'b0, 17, "s256_136B");
        check("s256_136B w16 const", got_d[16], 64'h8786858483828180);
        check("s256_136B w16 flags", {62'd0, got_bl[16], got_ml[16]}, 64'd2);
        check("s256_136B w17 const", got_d[17], 64'h000000000000001F);
        check("s256_136B w33 const", got_d[33], 64'h8000000000000000);
        check("s256_136B rate_words", 64'(rate_words), 64'd17);

        // SHAKE256, seven bytes in the block's last lane: 0x9F, no extra block.
        run_msg(135, 1'b1, 1'b0, 1'b0, 17, "s256_135B");
        check("s256_135B w16 const", got_d[16], 64'h9F86858483828180);

        // Empty SHAKE128 message.
        run_msg(0, 1'b0, 1'b0, 1'b0, 21, "s128_empty");
        check("s128_empty w0 const", got_d[0], 64'h000000000000001F);
        check("s128_empty w20 const", got_d[20], 64'h8000000000000000);
        check("s128_empty rate_words", 64'(rate_words), 64'd21);

        // Combinational final-word masking, no handshake (out_ready low).
        in_valid = 1'b1; out_ready = 1'b0; in_last = 1'b1; rate_sel = 1'b0;
        in_data = 64'h1122334455667788; in_bytes = 4'd5;
        #1;
        check("mask 5B data", out_data, 64'h00001F4455667788);
        check("mask 5B ready", 64'(in_ready), 64'd0);
        in_bytes = 4'd12;
        #1;
        check("mask 12B data", out_data, 64'h1122334455667788);
        check("mask 12B msg_last", 64'(out_msg_last), 64'd0);
        in_bytes = 4'd0;
        #1;
        check("mask 0B data", out_data, 64'h000000000000001F);
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Random stalls with rate_sel toggling mid-message.
        run_msg(135, 1'b1, 1'b1, 1'b1, 17, "stall_s256_135B");
        check("stall_s256_135B w16 const", got_d[16], 64'h9F86858483828180);
        run_msg(136, 1'b0, 1'b1, 1'b1, 21, "stall_s128_136B");
        run_msg(3, 1'b0, 1'b1, 1'b0, 21, "stall_s128_3B");

        // Reset pulsed mid-pad, then a fresh message.
        msg[0] = 8'hAA; msg[1] = 8'hBB; msg[2] = 8'hCC;
        in_valid = 1'b1; in_data = 64'hEEEEEEEEEECCBBAA; in_last = 1'b1;
        in_bytes = 4'd3; rate_sel = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_last = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check("midpad out_valid", 64'(out_valid), 64'd1);
        in_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        check("midpad rst out_valid", 64'(out_valid), 64'd0);
        check("midpad rst in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        #1;
        check("midpad rst rate_words", 64'(rate_words), 64'd21);
        @(posedge clk);
        #1;
        run_msg(3, 1'b0, 1'b0, 1'b0, 21, "post_rst_3B");
        check("post_rst_3B w0 const", got_d[0], 64'h000000001FCCBBAA);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
